xor_frame_sender: RTL and testbench

Transmit-side framer for the XOR cipher link. It buffers up to MAX_BYTES payload bytes and a repeating key of up to KEY_MAX bytes. On command it emits a frame of one length byte followed by each payload byte XORed with the key. Bytes go out one at a time through the Tx_Data/Tx_Send/Tx_Busy handshake of the existing UART_Sender. It produces the same length-prefixed byte stream that the receive path parses, so frames can be returned to the PC or looped back in test.

---
 rtl/xor_frame_sender.sv | 128 ++++++++++++
 tb/tb_xor_frame_sender.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_frame_sender.sv
// Transmit framer for the XOR cipher link: emits a length byte followed by
// the buffered payload XORed with a repeating key, one byte per UART handshake.
module xor_frame_sender #(
    parameter int MAX_BYTES = 100,
    parameter int KEY_MAX   = 3
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       Wr_En,
    input  logic [7:0] Wr_Data,
    input  logic       Key_Wr_En,
    input  logic [7:0] Key_Wr_Data,
    input  logic       Start,
    output logic [7:0] Tx_Data,
    output logic       Tx_Send,
    input  logic       Tx_Busy,
    output logic       Wr_Ready,
    output logic       Busy,
    output logic       Done,
    output logic       Overflow
);
    localparam int AW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int KW  = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int KCW = $clog2(KEY_MAX + 1);
    localparam logic [7:0]     MaxCount = 8'(MAX_BYTES);
    localparam logic [KCW-1:0] KeyMax   = KCW'(KEY_MAX);

    typedef enum logic [2:0] {LOAD, SEND_REQ, SEND_ACK, SEND_WAIT, DONE} stateT;

    stateT          state;
    logic [7:0]     payload [MAX_BYTES];
    logic [7:0]     keyBuf  [KEY_MAX];
    logic [7:0]     count, frameLen, byteIdx, rdData, txByte;
    logic [KCW-1:0] keyCount, keyIdx;
    logic           wrAccept, keyAccept;

    assign wrAccept  = (state == LOAD) && Wr_En && (count < MaxCount);
    assign keyAccept = (state == LOAD) && Key_Wr_En && (keyCount < KeyMax);
    assign Wr_Ready  = (state == LOAD) && (count < MaxCount);

    // Storage has no reset so the payload maps onto block RAM; the read is
    // issued as SEND_WAIT exits so data is ready when SEND_REQ loads it.
    always_ff @(posedge Clk_100M) begin
        if (wrAccept)
            payload[count[AW-1:0]] <= Wr_Data;
        if (keyAccept)
            keyBuf[keyCount[KW-1:0]] <= Key_Wr_Data;
        if (state == SEND_WAIT && !Tx_Busy && byteIdx < frameLen)
            rdData <= payload[byteIdx[AW-1:0]];
    end

    always_comb begin
        txByte = frameLen;
        if (byteIdx != 8'd0) begin
            txByte = rdData;
            if (keyCount != '0)
                txByte = rdData ^ keyBuf[keyIdx[KW-1:0]];
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state    <= LOAD;
            count    <= 8'd0;
            keyCount <= '0;
            keyIdx   <= '0;
            frameLen <= 8'd0;
            byteIdx  <= 8'd0;
            Tx_Data  <= 8'd0;
            Tx_Send  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                LOAD: begin
                    if (wrAccept)
                        count <= count + 8'd1;
                    else if (Wr_En)
                        Overflow <= 1'b1;
                    if (keyAccept)
                        keyCount <= keyCount + KCW'(1);
                    if (Start) begin
                        // a byte written alongside Start belongs to this frame
                        frameLen <= count + {7'd0, wrAccept};
                        byteIdx  <= 8'd0;
                        keyIdx   <= '0;
                        Busy     <= 1'b1;
                        state    <= SEND_REQ;
                    end
                end
                SEND_REQ: begin
                    if (!Tx_Busy) begin
                        Tx_Data <= txByte;
                        Tx_Send <= 1'b1;
                        state   <= SEND_ACK;
                        if (byteIdx != 8'd0 && keyCount != '0)
                            keyIdx <= (keyIdx == keyCount - KCW'(1)) ? '0 : keyIdx + KCW'(1);
                    end
                end
                SEND_ACK: begin
                    if (Tx_Busy) begin
                        Tx_Send <= 1'b0;
                        state   <= SEND_WAIT;
                    end
                end
                SEND_WAIT: begin
                    if (!Tx_Busy) begin
                        if (byteIdx < frameLen) begin
                            byteIdx <= byteIdx + 8'd1;
                            state   <= SEND_REQ;
                        end else begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    count <= 8'd0;
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_frame_sender.sv
// Randomized bench for xor_frame_sender: a UART responder captures the byte
// stream, which is compared with frames built from queued payload and keys.
module tb_xor_frame_sender;
    localparam int MAX_BYTES = 100;
    localparam int KEY_MAX   = 3;

    logic       Clk_100M = 1'b0;
    logic       Reset = 1'b1;
    logic       Wr_En = 1'b0, Key_Wr_En = 1'b0, Start = 1'b0;
    logic [7:0] Wr_Data = 8'd0, Key_Wr_Data = 8'd0;
    logic       Tx_Busy = 1'b0;
    logic [7:0] Tx_Data;
    logic       Tx_Send, Wr_Ready, Busy, Done, Overflow;

    always #5 Clk_100M = ~Clk_100M;

    xor_frame_sender #(.MAX_BYTES(MAX_BYTES), .KEY_MAX(KEY_MAX)) dut (
        .Clk_100M(Clk_100M), .Reset(Reset),
        .Wr_En(Wr_En), .Wr_Data(Wr_Data),
        .Key_Wr_En(Key_Wr_En), .Key_Wr_Data(Key_Wr_Data),
        .Start(Start), .Tx_Data(Tx_Data), .Tx_Send(Tx_Send), .Tx_Busy(Tx_Busy),
        .Wr_Ready(Wr_Ready), .Busy(Busy), .Done(Done), .Overflow(Overflow)
    );

    int nChecks = 0, nErrors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference state: what the payload and key buffers should hold
    logic [7:0] mBuf[$];
    logic [7:0] mKey[$];
    bit         mOvf = 1'b0;

    // UART responder: raises busy uartDly cycles after a request, holds uartHold cycles
    logic [7:0] rxQ[$];
    int uartDly = 2, uartHold = 20, phase = 0, cnt = 0;

    always @(posedge Clk_100M) begin
        if (Reset) begin
            Tx_Busy <= 1'b0;
            phase   <= 0;
        end else begin
            case (phase)
                0: if (Tx_Send) begin
                    rxQ.push_back(Tx_Data);
                    cnt   <= uartDly;
                    phase <= 1;
                end
                1: if (cnt == 0) begin
                    Tx_Busy <= 1'b1;
                    cnt     <= uartHold;
                    phase   <= 2;
                end else cnt <= cnt - 1;
                default: if (cnt <= 1) begin
                    Tx_Busy <= 1'b0;
                    phase   <= 0;
                end else cnt <= cnt - 1;
            endcase
        end
    end

    // Tx_Data may only move on a Tx_Send rise (or reset)
    int         txRises = 0;
    logic       prevSend = 1'b0;
    logic [7:0] prevData = 8'd0;
    always @(posedge Clk_100M) begin
        #1;
        if (!Reset && !(Tx_Send && !prevSend))
            chk("txDataHold", Tx_Data, prevData);
        if (Tx_Send && !prevSend)
            txRises++;
        prevSend = Tx_Send;
        prevData = Tx_Data;
    end

    task automatic tick();
        @(negedge Clk_100M);
    endtask

    task automatic writeByte(input logic [7:0] b);
        Wr_En = 1'b1; Wr_Data = b;
        tick();
        Wr_En = 1'b0;
        if (mBuf.size() < MAX_BYTES) mBuf.push_back(b);
        else mOvf = 1'b1;
    endtask

    task automatic writeKey(input logic [7:0] k);
        Key_Wr_En = 1'b1; Key_Wr_Data = k;
        tick();
        Key_Wr_En = 1'b0;
        if (mKey.size() < KEY_MAX) mKey.push_back(k);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        mBuf.delete(); mKey.delete(); mOvf = 1'b0; rxQ.delete();
    endtask

    task automatic runFrame(input string name, input bit withWr, input logic [7:0] wb, input bit junk);
        logic [7:0] exp[$];
        int  rises0;
        bit  gotDone;
        if (withWr && mBuf.size() < MAX_BYTES) mBuf.push_back(wb);
        exp.push_back(8'(mBuf.size()));
        foreach (mBuf[i])
            exp.push_back(mKey.size() == 0 ? mBuf[i] : mBuf[i] ^ mKey[i % mKey.size()]);
        rxQ.delete();
        rises0 = txRises;
        Start = 1'b1;
        if (withWr) begin Wr_En = 1'b1; Wr_Data = wb; end
        tick();
        Start = 1'b0; Wr_En = 1'b0;
        chk({name, ".busyAfterStart"}, Busy, 1);
        chk({name, ".sendNotYet"}, Tx_Send, 0);
        tick();
        chk({name, ".sendRise"}, Tx_Send, 1);
        gotDone = 1'b0;
        for (int c = 0; c < 8000 && !gotDone; c++) begin
            Wr_En = 1'b0; Key_Wr_En = 1'b0; Start = 1'b0;
            tick();
            if (Done) begin
                gotDone = 1'b1;
                chk({name, ".busyAtDone"}, Busy, 0);
            end else if (junk && Busy && $urandom_range(0, 2) == 0) begin
                Wr_En = 1'b1; Wr_Data = 8'($urandom);
                Key_Wr_En = 1'b1; Key_Wr_Data = 8'($urandom);
                Start = 1'b1;
            end
        end
        Wr_En = 1'b0; Key_Wr_En = 1'b0; Start = 1'b0;
        chk({name, ".done"}, gotDone, 1);
        tick();
        chk({name, ".donePulse"}, Done, 0);
        chk({name, ".wrReady"}, Wr_Ready, 1);
        repeat (30) tick();
        chk({name, ".rises"}, txRises - rises0, exp.size());
        chk({name, ".len"}, rxQ.size(), exp.size());
        foreach (exp[i])
            chk($sformatf("%s.byte%0d", name, i), (i < rxQ.size()) ? rxQ[i] : 32'hdead, exp[i]);
        mBuf.delete();
    endtask

    int  r0;
    bit  found;

    initial begin
        tick(); tick();
        Reset = 1'b0;
        chk("rst.txData", Tx_Data, 0);
        chk("rst.txSend", Tx_Send, 0);
        chk("rst.busy", Busy, 0);
        chk("rst.done", Done, 0);
        chk("rst.overflow", Overflow, 0);
        chk("rst.wrReady", Wr_Ready, 1);

        writeByte(8'h41); writeByte(8'h42); writeByte(8'h43);
        writeKey(8'h01); writeKey(8'h02);
        runFrame("basic", 0, 8'h00, 0);
        runFrame("empty", 0, 8'h00, 0);

        doReset();
        writeByte(8'h55);
        runFrame("nokey", 0, 8'h00, 0);

        writeByte(8'h11); writeByte(8'h22);
        runFrame("simul", 1, 8'h7E, 0);

        writeKey(8'hA5); writeKey(8'h3C);
        repeat (4) writeByte(8'($urandom));
        runFrame("junk", 0, 8'h00, 1);
        repeat (3) writeByte(8'($urandom));
        runFrame("keysKept", 0, 8'h00, 0);

        for (int f = 0; f < 6; f++) begin
            int nk, nb;
            doReset();
            nk = $urandom_range(0, 4);
            nb = $urandom_range(0, 12);
            for (int k = 0; k < nk; k++) writeKey(8'($urandom));
            for (int b = 0; b < nb; b++) writeByte(8'($urandom));
            chk("rand.keyNoOvf", Overflow, mOvf);
            uartDly  = $urandom_range(0, 3);
            uartHold = $urandom_range(1, 20);
            runFrame($sformatf("rand%0d", f), 0, 8'h00, 0);
        end

        doReset();
        uartDly = 0; uartHold = 3;
        for (int b = 0; b <= MAX_BYTES; b++) writeByte(8'($urandom));
        chk("full.overflow", Overflow, mOvf);
        chk("full.wrReady", Wr_Ready, 0);
        writeKey(8'h5A);
        runFrame("full", 0, 8'h00, 0);
        chk("full.overflowSticky", Overflow, 1);

        doReset();
        uartDly = 2; uartHold = 20;
        writeKey(8'h0F);
        writeByte(8'h01); writeByte(8'h02); writeByte(8'h03);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        r0 = txRises;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            tick();
            if (Tx_Send && txRises - r0 == 3) found = 1'b1;
        end
        chk("midRst.reachedByte2", found, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midRst.txSend", Tx_Send, 0);
        chk("midRst.busy", Busy, 0);
        chk("midRst.txData", Tx_Data, 0);
        chk("midRst.done", Done, 0);
        mBuf.delete(); mKey.delete(); mOvf = 1'b0; rxQ.delete();
        tick();
        writeByte(8'h10);
        runFrame("afterRst", 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
